// File: rtl/spdif_pkg.sv
// rtl/spdif_pkg.sv - shared SPDIF types: preamble codes, receiver states, UI run classes
package spdif_pkg;

    typedef enum logic [1:0] {
        PRE_B = 2'd0,
        PRE_M = 2'd1,
        PRE_W = 2'd2
    } preamble_t;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        PARITY   = 2'd3
    } rx_state_t;

    localparam logic [1:0] UI_BAD = 2'd0;
    localparam logic [1:0] UI_1   = 2'd1;
    localparam logic [1:0] UI_2   = 2'd2;
    localparam logic [1:0] UI_3   = 2'd3;

    // The run after the leading 3 UI run identifies the preamble: B=1, M=3, W=2.
    function automatic preamble_t preamble_of(input logic [1:0] second_run);
        case (second_run)
            UI_1:    return PRE_B;
            UI_3:    return PRE_M;
            default: return PRE_W;
        endcase
    endfunction

    function automatic logic [1:0] preamble_last_run(input preamble_t p);
        case (p)
            PRE_B:   return UI_3;
            PRE_M:   return UI_1;
            default: return UI_2;
        endcase
    endfunction

endpackage

// File: rtl/spdif_run_classifier.sv
// rtl/spdif_run_classifier.sv - line synchronizer, edge detector, run timer and UI classifier
module spdif_run_classifier
    import spdif_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_i,
    output logic       run_valid_o,
    output logic [1:0] run_class_o
);
    localparam int SAT = 4 * HALF_BIT_CYCLES;
    localparam int CW  = $clog2(SAT + 1);
    // Thresholds are compared against twice the run length so odd H stays exact.
    localparam logic [CW:0] LIM_1 = (CW+1)'(HALF_BIT_CYCLES);
    localparam logic [CW:0] LIM_3 = (CW+1)'(3 * HALF_BIT_CYCLES);
    localparam logic [CW:0] LIM_5 = (CW+1)'(5 * HALF_BIT_CYCLES);
    localparam logic [CW:0] LIM_7 = (CW+1)'(7 * HALF_BIT_CYCLES);

    logic [2:0]    sync_q;
    logic [CW-1:0] run_cnt_q, run_cnt_d;
    logic [CW:0]   run_x2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q    <= '0;
            run_cnt_q <= '0;
        end else begin
            sync_q    <= {sync_q[1:0], serial_i};
            run_cnt_q <= run_cnt_d;
        end
    end

    assign run_valid_o = sync_q[1] ^ sync_q[2];

    always_comb begin
        if (run_valid_o)
            run_cnt_d = CW'(1);
        else if (run_cnt_q == CW'(SAT))
            run_cnt_d = run_cnt_q;
        else
            run_cnt_d = run_cnt_q + 1'b1;
    end

    assign run_x2 = {run_cnt_q, 1'b0};

    always_comb begin
        if (run_x2 < LIM_1)
            run_class_o = UI_BAD;
        else if (run_x2 < LIM_3)
            run_class_o = UI_1;
        else if (run_x2 < LIM_5)
            run_class_o = UI_2;
        else if (run_x2 < LIM_7)
            run_class_o = UI_3;
        else
            run_class_o = UI_BAD;
    end

endmodule

// File: rtl/spdif_receiver.sv
// rtl/spdif_receiver.sv - biphase-mark subframe receiver: preamble match, data shift, parity check
module spdif_receiver
    import spdif_pkg::*;
#(
    parameter int WIDTH           = 11,
    parameter int HALF_BIT_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             SerialIn,
    output logic [WIDTH-1:0] RxData,
    output logic             RxValid,
    output logic [1:0]       RxPreamble,
    output logic             ParityError,
    output logic             CodeError,
    output logic             Locked
);
    localparam int BCW = $clog2(WIDTH + 1);

    logic             run_valid;
    logic [1:0]       run_class;
    rx_state_t        state_q, state_d;
    logic [1:0]       pre_idx_q, pre_run1_q;
    preamble_t        pre_q;
    logic             half_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic             run_bad, bit_done, bit_val, pre_done;
    logic             rx_valid_d, code_err_d;
    logic [WIDTH-1:0] rx_data_q;
    logic [1:0]       rx_pre_q;
    logic             rx_valid_q, parity_err_q, code_err_q, locked_q;

    spdif_run_classifier #(.HALF_BIT_CYCLES(HALF_BIT_CYCLES)) u_classifier (
        .clock       (clock),
        .reset       (reset),
        .serial_i    (SerialIn),
        .run_valid_o (run_valid),
        .run_class_o (run_class)
    );

    // Per-run decode shared by the next-state and output logic.
    always_comb begin
        run_bad  = 1'b0;
        bit_done = 1'b0;
        pre_done = 1'b0;
        bit_val  = (run_class == UI_1);
        if (run_valid) begin
            case (state_q)
                HUNT: run_bad = 1'b0;
                PREAMBLE: begin
                    case (pre_idx_q)
                        2'd0:    run_bad = (run_class != UI_3);
                        2'd1:    run_bad = (run_class == UI_BAD);
                        2'd2:    run_bad = (run_class != UI_1);
                        default: begin
                            run_bad  = (run_class != preamble_last_run(preamble_of(pre_run1_q)));
                            pre_done = !run_bad;
                        end
                    endcase
                end
                default: begin
                    if (run_class == UI_1)
                        bit_done = half_q;
                    else if (run_class == UI_2 && !half_q)
                        bit_done = 1'b1;
                    else
                        run_bad = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= HUNT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (run_bad)
            state_d = HUNT;
        else if (run_valid) begin
            case (state_q)
                HUNT:     if (run_class == UI_3) state_d = PREAMBLE;
                PREAMBLE: if (pre_done) state_d = DATA;
                DATA:     if (bit_done && bit_cnt_q == BCW'(WIDTH - 1)) state_d = PARITY;
                default:  if (bit_done) state_d = PREAMBLE;
            endcase
        end
    end

    always_comb begin
        code_err_d = run_bad;
        rx_valid_d = (state_q == PARITY) && bit_done && !run_bad;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_idx_q  <= '0;
            pre_run1_q <= '0;
            pre_q      <= PRE_B;
            half_q     <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else if (run_valid) begin
            case (state_q)
                // Leaving HUNT consumes the leading 3 UI run.
                HUNT: pre_idx_q <= 2'd1;
                PREAMBLE: begin
                    pre_idx_q <= pre_idx_q + 2'd1;
                    if (pre_idx_q == 2'd1)
                        pre_run1_q <= run_class;
                    if (pre_done) begin
                        pre_q     <= preamble_of(pre_run1_q);
                        bit_cnt_q <= '0;
                        half_q    <= 1'b0;
                    end
                end
                default: begin
                    half_q <= (run_class == UI_1) && !half_q;
                    if (bit_done && state_q == DATA) begin
                        shift_q   <= {bit_val, shift_q[WIDTH-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    if (bit_done && state_q == PARITY)
                        pre_idx_q <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data_q    <= '0;
            rx_pre_q     <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            code_err_q   <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid_d;
            code_err_q <= code_err_d;
            if (rx_valid_d) begin
                rx_data_q    <= shift_q;
                rx_pre_q     <= pre_q;
                parity_err_q <= (^shift_q) ^ bit_val;
            end
            if (code_err_d)
                locked_q <= 1'b0;
            else if (rx_valid_d)
                locked_q <= 1'b1;
        end
    end

    assign RxData      = rx_data_q;
    assign RxValid     = rx_valid_q;
    assign RxPreamble  = rx_pre_q;
    assign ParityError = parity_err_q;
    assign CodeError   = code_err_q;
    assign Locked      = locked_q;

endmodule

// File: doc/spdif_receiver.md
SPDIF_RECEIVER -- requirements
Module: spdif_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 11: number of audio data bits per subframe.
REQ-002 SHALL have parameter HALF_BIT_CYCLES, default 4: clock cycles per biphase half-cell (unit interval, UI).
REQ-003 SHALL have port clock, input, 1: single clock; every register is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port SerialIn, input, 1: asynchronous biphase-mark line from the SPDIF transmitter.
REQ-006 SHALL have port RxData, output, WIDTH: decoded data word, LSB received first.
REQ-007 SHALL have port RxValid, output, 1: one-cycle pulse; RxData, RxPreamble and ParityError are valid in that cycle.
REQ-008 SHALL have port RxPreamble, output, 2: preamble that opened the subframe; B=0, M=1, W=2.
REQ-009 SHALL have port ParityError, output, 1: even-parity check over data plus parity bit failed.
REQ-010 SHALL have port CodeError, output, 1: one-cycle pulse on a biphase or preamble violation.
REQ-011 SHALL have port Locked, output, 1: receiver aligned to subframes.

Function
REQ-012 SHALL pass SerialIn through a 2-flop synchronizer, then an edge detector (flop2 XOR flop3).
REQ-013 SHALL measure each run between detected edges in clocks, with a counter saturating at 4*HALF_BIT_CYCLES.
REQ-014 SHALL classify a run with H=HALF_BIT_CYCLES as follows: [H/2, 3H/2) = 1 UI; [3H/2, 5H/2) = 2 UI; [5H/2, 7H/2) = 3 UI; otherwise invalid (H=4: 2-5, 6-9, 10-13 clocks).
REQ-015 SHALL implement FSM states HUNT, PREAMBLE, DATA, PARITY.
REQ-016 SHALL, in HUNT, ignore all runs until a 3 UI run, then enter PREAMBLE.
REQ-017 SHALL, in PREAMBLE, match the run sequence starting with the 3 UI run: B=3,1,1,3; M=3,3,1,1; W=3,2,1,2 (8 UI total).
REQ-018 SHALL, on a complete preamble match, latch RxPreamble and enter DATA with bit count 0.
REQ-019 SHALL, in DATA and PARITY, decode one 2 UI run as bit 0 and two consecutive 1 UI runs as bit 1.
REQ-020 SHALL treat a 1 UI run followed by a 2 or 3 UI run as a violation.
REQ-021 SHALL shift data bits LSB-first; after WIDTH bits enter PARITY; the next decoded bit is parity.
REQ-022 SHALL, on completing the parity cell, pulse RxValid and update RxData and ParityError, 3 clock cycles after the SerialIn transition that closes the parity cell.
REQ-023 SHALL, after the parity cell, return to PREAMBLE expecting a 3 UI run.
REQ-024 SHALL, on any invalid run, violation or preamble mismatch: pulse CodeError, clear Locked, go to HUNT, suppress RxValid.
REQ-025 SHALL give CodeError precedence if a violation coincides with parity completion: no RxValid.
REQ-026 SHALL set Locked on the first RxValid and keep it until CodeError or reset.
REQ-027 SHALL hold RxData, RxPreamble and ParityError between RxValid pulses.

Reset
REQ-028 SHALL, with reset high at a clock edge, clear all outputs to 0, FSM to HUNT, and synchronizer, run counter and shift register to 0.
REQ-029 SHALL, on reset asserted mid-subframe, discard the partial word; after release, no RxValid occurs before a fresh preamble.

Structure
REQ-030 SHALL put the preamble_t enum (B/M/W), the FSM state enum and the UI-class constants in shared package spdif_pkg, also used by the transmitter side.
REQ-031 SHALL contain one sub-module, spdif_run_classifier (synchronizer, edge detect, run counter, UI classification), instantiated once.

Verification
REQ-032 SHALL cover: with H=4, behavioural biphase source sends B preamble, data 11'b11110100001, correct parity -> one RxValid, RxData=11'h7A1, RxPreamble=0, ParityError=0, Locked=1.
REQ-033 SHALL cover: sequence M, W subframes with random data -> RxPreamble 1 then 2; each RxData matches the sent word; RxValid pulses are exactly 8+2*(WIDTH+1) UI apart.
REQ-034 SHALL cover: parity bit inverted -> RxValid with ParityError=1; Locked stays 1.
REQ-035 SHALL cover: a 1 UI run followed by a 2 UI run inside the data field -> CodeError pulse, Locked=0, no RxValid; relock on the next valid subframe.
REQ-036 SHALL cover: run jitter of ±1 clock on every edge -> decoding identical to the clean case; a 15-clock run -> CodeError.
REQ-037 SHALL cover: reset pulsed mid-data -> all outputs 0 next cycle; next RxValid only after a full new subframe.
